// File: rtl/serial_arith_pkg.sv
// Shared types and helpers for the digit-serial adder: FSM state encoding
// and a constant-evaluable ceiling log2.
package serial_arith_pkg;

  // 2'd3 is unused; the FSM treats it as IDLE on the next edge.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Operand/result bundle between a requester (master) and the serial adder (slave).
interface serial_adder_if #(
  parameter int WIDTH = 8
);

  // Handshake: start is sampled only while done=1 or the adder is idle
  // (busy=0); the edge that samples it high captures a/b/cin. busy is high
  // for the whole RUN phase and start is ignored there. done is a one-cycle
  // pulse; sum/cout/overflow are valid from done until the next accept.
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;
  logic             busy;
  logic             done;

  modport master (
    output start, a, b, cin,
    input  sum, cout, overflow, busy, done
  );

  modport slave (
    input  start, a, b, cin,
    output sum, cout, overflow, busy, done
  );

endinterface

// File: rtl/serial_adder_digit_adder.sv
// DIGIT-bit ripple-carry adder built from full-adder cells; also exposes the
// carry into its top bit so the caller can form signed overflow.
module digit_adder #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co,
  output logic             c_msb
);

  logic [DIGIT:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    assign s[i]   = x[i] ^ y[i] ^ c[i];
    assign c[i+1] = (x[i] & y[i]) | (x[i] & c[i]) | (y[i] & c[i]);
  end

  assign co    = c[DIGIT];
  assign c_msb = c[DIGIT-1];

endmodule

// File: rtl/serial_adder.sv
// Digit-serial adder: one DIGIT-bit adder reused over WIDTH/DIGIT cycles,
// LSB digit first, with start/busy/done handshake, carry-out and overflow.
module serial_adder
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  serial_adder_if.slave    bus,
  output state_e           dbg_state_o
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (clog2(NDIG) < 1) ? 1 : clog2(NDIG);

  if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
    $error("serial_adder: DIGIT must be >= 1 and divide WIDTH exactly");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             accept;

  logic [DIGIT-1:0] dig_s;
  logic             dig_co;
  logic             dig_c_msb;
  logic [WIDTH-1:0] sum_shift;
  logic             last_digit;

  digit_adder #(
    .DIGIT (DIGIT)
  ) u_digit_adder (
    .x     (a_q[DIGIT-1:0]),
    .y     (b_q[DIGIT-1:0]),
    .ci    (carry_q),
    .s     (dig_s),
    .co    (dig_co),
    .c_msb (dig_c_msb)
  );

  // New digits enter at the top so the first (LSB) digit lands at bit 0.
  if (NDIG == 1) begin : g_single
    assign sum_shift = dig_s;
  end else begin : g_multi
    assign sum_shift = {dig_s, sum_q[WIDTH-1:DIGIT]};
  end

  assign last_digit = (cnt_q == CW'(NDIG - 1));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          accept = 1'b1;
        end
      end
      RUN: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        sum_d   = sum_shift;
        carry_d = dig_co;
        cnt_d   = cnt_q + CW'(1);
        if (last_digit) begin
          cout_d  = dig_co;
          ovf_d   = dig_c_msb ^ dig_co;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
        if (bus.start) begin
          accept = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (accept) begin
      state_d = RUN;
      a_d     = bus.a;
      b_d     = bus.b;
      carry_d = bus.cin;
      cnt_d   = '0;
      sum_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.sum      = sum_q;
  assign bus.cout     = cout_q;
  assign bus.overflow = ovf_q;
  assign bus.busy     = (state_q == RUN);
  assign bus.done     = (state_q == DONE);
  assign dbg_state_o  = state_q;

endmodule
